ctrl_pipeline: RTL
==================

// Module: ctrl_pipeline
// PURPOSE
//  Consumer end of the main-decoder control bundle. Registers the control word
//  through the ID/EX, EX/MEM and MEM/WB stages and presents the stage-correct bits to the datapath.
//  Detects load-use hazards, generates EX operand forwarding selects, and inserts bubbles
//  on branch/jump redirect. Sits between the decoder and the 5-stage datapath.
// PARAMETERS
//  REG_ADDR_W  5  register-index width
//  ALUOP_W     3  width of ALUOp
// PORTS
//  CLK             in   1          clock, all state on rising edge
//  RST_n           in   1          synchronous, active-low reset
//  ID_Branch, ID_MemRead, ID_MemtoReg, ID_MemWrite, ID_ALUSrc, ID_RegWrite, ID_Jump  in  1 each  decoder bits
//  ID_ALUOp        in   ALUOP_W    decoder ALUOp
//  ID_AuipcLui     in   2          decoder AuipcLui
//  ID_Rs1/ID_Rs2/ID_Rd  in  REG_ADDR_W  register fields of the instruction in ID
//  EX_Redirect     in   1          EX resolved taken branch or jump this cycle
//  EX_ALUOp        out  ALUOP_W    EX control
//  EX_ALUSrc, EX_Branch, EX_Jump  out  1 each  EX control
//  EX_AuipcLui     out  2          EX control
//  EX_Rs1/EX_Rs2/EX_Rd  out  REG_ADDR_W  register indices carried into EX
//  MEM_MemRead, MEM_MemWrite  out  1 each  MEM control
//  WB_MemtoReg, WB_RegWrite   out  1 each  WB control
//  WB_Rd           out  REG_ADDR_W register-file write index
//  ForwardA/ForwardB  out  2       EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  PCWrite         out  1          0 = hold PC
//  IFIDWrite       out  1          0 = hold IF/ID
//  IFIDFlush       out  1          1 = IF/ID loads a NOP
// BEHAVIOUR
//  - Reset (RST_n=0 at an edge): all stage registers hold the bubble. All control bits are 0, ALUOp=0, AuipcLui=0 and the indices are 0.
//    After reset, the combinational outputs are: ForwardA/B=00, PCWrite=1, IFIDWrite=1, IFIDFlush=0.
//  - Reset mid-operation discards every in-flight control word at that edge.
//  - Latency: an ID control word appears on the EX_* outputs 1 cycle later, MEM_* 2 cycles later and WB_* 3 cycles later.
//  - Load-use hazard is asserted when all hold: EX_MemRead=1, EX_Rd!=0, and (EX_Rd==ID_Rs1 or EX_Rd==ID_Rs2).
//    While asserted: PCWrite=0 and IFIDWrite=0; ID/EX loads the bubble; EX/MEM and MEM/WB advance normally.
//    Exactly one bubble is inserted per load-use pair.
//  - Redirect (EX_Redirect=1): IFIDFlush=1; ID/EX loads the bubble; PCWrite=1 and IFIDWrite=1.
//    Redirect overrides a load-use hazard in the same cycle. The EX instruction itself proceeds to MEM.
//  - Forwarding (combinational, from registered state; ForwardB is identical using EX_Rs2):
//    ForwardA=10 if MEM RegWrite and MEM rd!=0 and MEM rd==EX_Rs1.
//    Else ForwardA=01 if WB_RegWrite and WB_Rd!=0 and WB_Rd==EX_Rs1.
//    Else ForwardA=00. EX/MEM has priority when both stages match.
//  - x0 never causes a stall or a forward.
//  - There is no saturation and no wrap: this is pure state transfer, and indices pass through unchanged.
// STRUCTURE
//  - Shared package riscv_ctrl_pkg:
//    ctrl_word_t packed struct holding all decoder bits;
//    CTRL_BUBBLE constant (all zero);
//    FWD_REG=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01;
//    ALUOp encodings 000..101.
//  - One sub-module: ctrl_hazard_fwd (combinational stall/flush/forward logic).
//    The parent holds the three stage registers.
// TESTING
//  - Reset: hold RST_n=0 for 2 cycles while ID carries R-type (RegWrite=1) -> all outputs are bubble and PCWrite=1 throughout.
//  - Pipe: R-type ALUOp=000 in ID -> EX_ALUOp=000 at +1; MEM outputs 0 at +2; WB_RegWrite=1 and WB_Rd=ID_Rd at +3.
//  - Load-use: lw x5 in EX, add with Rs1=5 in ID -> PCWrite=0 and IFIDWrite=0 for 1 cycle; next EX is bubble;
//    then ForwardA=01 when the add reaches EX.
//  - Forward priority: x7 written in both MEM and WB, EX_Rs2=7 -> ForwardB=10. Same case with rd=0 -> 00.
//  - Redirect with simultaneous load-use: EX_Redirect=1 and the hazard condition true ->
//    IFIDFlush=1, PCWrite=1, next EX is bubble, no extra stall cycle.
//  - x0: lw x0 in EX, ID_Rs1=0 -> no stall.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared control-bundle types for the decoder-to-datapath control pipeline.
package riscv_ctrl_pkg;

  localparam int unsigned CTRL_ALUOP_W = 3;

  typedef enum logic [CTRL_ALUOP_W-1:0] {
    AluAdd   = 3'b000,
    AluSub   = 3'b001,
    AluAnd   = 3'b010,
    AluOr    = 3'b011,
    AluSlt   = 3'b100,
    AluPassB = 3'b101
  } aluop_e;

  typedef struct packed {
    logic                    branch;
    logic                    memread;
    logic                    memtoreg;
    logic                    memwrite;
    logic                    alusrc;
    logic                    regwrite;
    logic                    jump;
    logic [CTRL_ALUOP_W-1:0] aluop;
    logic [1:0]              auipclui;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/ctrl_hazard_fwd.sv
// Combinational load-use stall, redirect flush and EX operand forwarding selects.
module ctrl_hazard_fwd
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] ex_rs1_i,
  input  logic [REG_ADDR_W-1:0] ex_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  mem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  wb_regwrite_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  redirect_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic [1:0]            forward_a_o,
  output logic [1:0]            forward_b_o
);

  logic load_use;
  logic stall;

  // EX/MEM wins over MEM/WB because it holds the younger write.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_REG;
    if (mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == src)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = ex_memread_i && (ex_rd_i != '0) &&
               ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    // A redirect squashes the ID instruction anyway, so the stall is pointless.
    stall         = load_use && !redirect_i;
    pc_write_o    = !stall;
    ifid_write_o  = !stall;
    ifid_flush_o  = redirect_i;
    idex_bubble_o = load_use || redirect_i;
    forward_a_o   = fwd_sel(ex_rs1_i);
    forward_b_o   = fwd_sel(ex_rs2_i);
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries the decoder control word through ID/EX, EX/MEM and MEM/WB and drives
// stall, flush and forwarding controls for the 5-stage datapath.
module ctrl_pipeline
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 3
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  ID_Branch,
  input  logic                  ID_MemRead,
  input  logic                  ID_MemtoReg,
  input  logic                  ID_MemWrite,
  input  logic                  ID_ALUSrc,
  input  logic                  ID_RegWrite,
  input  logic                  ID_Jump,
  input  logic [ALUOP_W-1:0]    ID_ALUOp,
  input  logic [1:0]            ID_AuipcLui,
  input  logic [REG_ADDR_W-1:0] ID_Rs1,
  input  logic [REG_ADDR_W-1:0] ID_Rs2,
  input  logic [REG_ADDR_W-1:0] ID_Rd,
  input  logic                  EX_Redirect,
  output logic [ALUOP_W-1:0]    EX_ALUOp,
  output logic                  EX_ALUSrc,
  output logic                  EX_Branch,
  output logic                  EX_Jump,
  output logic [1:0]            EX_AuipcLui,
  output logic [REG_ADDR_W-1:0] EX_Rs1,
  output logic [REG_ADDR_W-1:0] EX_Rs2,
  output logic [REG_ADDR_W-1:0] EX_Rd,
  output logic                  MEM_MemRead,
  output logic                  MEM_MemWrite,
  output logic                  WB_MemtoReg,
  output logic                  WB_RegWrite,
  output logic [REG_ADDR_W-1:0] WB_Rd,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  IFIDFlush
);

  ctrl_word_t            ex_ctrl_d, ex_ctrl_q;
  logic [REG_ADDR_W-1:0] ex_rs1_d, ex_rs1_q, ex_rs2_d, ex_rs2_q, ex_rd_d, ex_rd_q;
  logic                  mem_memread_q, mem_memwrite_q, mem_memtoreg_q, mem_regwrite_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic                  wb_memtoreg_q, wb_regwrite_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic                  idex_bubble;

  ctrl_hazard_fwd #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_fwd (
    .ex_memread_i  (ex_ctrl_q.memread),
    .ex_rd_i       (ex_rd_q),
    .ex_rs1_i      (ex_rs1_q),
    .ex_rs2_i      (ex_rs2_q),
    .id_rs1_i      (ID_Rs1),
    .id_rs2_i      (ID_Rs2),
    .mem_regwrite_i(mem_regwrite_q),
    .mem_rd_i      (mem_rd_q),
    .wb_regwrite_i (wb_regwrite_q),
    .wb_rd_i       (wb_rd_q),
    .redirect_i    (EX_Redirect),
    .pc_write_o    (PCWrite),
    .ifid_write_o  (IFIDWrite),
    .ifid_flush_o  (IFIDFlush),
    .idex_bubble_o (idex_bubble),
    .forward_a_o   (ForwardA),
    .forward_b_o   (ForwardB)
  );

  always_comb begin
    ex_ctrl_d = CTRL_BUBBLE;
    ex_rs1_d  = '0;
    ex_rs2_d  = '0;
    ex_rd_d   = '0;
    if (!idex_bubble) begin
      ex_ctrl_d.branch   = ID_Branch;
      ex_ctrl_d.memread  = ID_MemRead;
      ex_ctrl_d.memtoreg = ID_MemtoReg;
      ex_ctrl_d.memwrite = ID_MemWrite;
      ex_ctrl_d.alusrc   = ID_ALUSrc;
      ex_ctrl_d.regwrite = ID_RegWrite;
      ex_ctrl_d.jump     = ID_Jump;
      ex_ctrl_d.aluop    = CTRL_ALUOP_W'(ID_ALUOp);
      ex_ctrl_d.auipclui = ID_AuipcLui;
      ex_rs1_d           = ID_Rs1;
      ex_rs2_d           = ID_Rs2;
      ex_rd_d            = ID_Rd;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      ex_ctrl_q      <= CTRL_BUBBLE;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_rd_q       <= '0;
      wb_memtoreg_q  <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_rd_q        <= '0;
    end else begin
      ex_ctrl_q      <= ex_ctrl_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      mem_memread_q  <= ex_ctrl_q.memread;
      mem_memwrite_q <= ex_ctrl_q.memwrite;
      mem_memtoreg_q <= ex_ctrl_q.memtoreg;
      mem_regwrite_q <= ex_ctrl_q.regwrite;
      mem_rd_q       <= ex_rd_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_rd_q        <= mem_rd_q;
    end
  end

  assign EX_ALUOp     = ALUOP_W'(ex_ctrl_q.aluop);
  assign EX_ALUSrc    = ex_ctrl_q.alusrc;
  assign EX_Branch    = ex_ctrl_q.branch;
  assign EX_Jump      = ex_ctrl_q.jump;
  assign EX_AuipcLui  = ex_ctrl_q.auipclui;
  assign EX_Rs1       = ex_rs1_q;
  assign EX_Rs2       = ex_rs2_q;
  assign EX_Rd        = ex_rd_q;
  assign MEM_MemRead  = mem_memread_q;
  assign MEM_MemWrite = mem_memwrite_q;
  assign WB_MemtoReg  = wb_memtoreg_q;
  assign WB_RegWrite  = wb_regwrite_q;
  assign WB_Rd        = wb_rd_q;

endmodule
